// File: rtl/dcache_mem_responder_pkg.sv
// Shared definitions for the dcache memory responder: default geometry,
// responder state encoding, request size codes and the byte-lane mask helper.
package dcache_mem_responder_pkg;

    // Default cache/RAM geometry used by the responder when not overridden
    localparam int DCACHE_OFFSET_WIDTH = 2;
    localparam int MEM_ADDR_WIDTH      = 10;
    localparam int READ_LATENCY        = 3;

    // Responder FSM states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_RESP = 2'd2
    } resp_state_e;

    // Request size codes; code 3 behaves like a full word
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Byte lanes a request of the given size may touch at the given byte offset
    function automatic logic [3:0] size_mask(input logic [1:0] size,
                                             input logic [1:0] addr_lo);
        logic [3:0] mask;
        case (size)
            SZ_BYTE: mask = 4'b0001 << addr_lo;
            SZ_HALF: mask = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: mask = 4'b1111;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/dcache_mem_responder_bank.sv
// One word-wide RAM bank: a byte-enabled request write port, a full-word
// backdoor write port and a combinational read port. The array is not reset.
module mem_bank_ram #(
    parameter int ROW_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 req_we,
    input  logic [ROW_WIDTH-1:0] req_row,
    input  logic [3:0]           req_be,
    input  logic [31:0]          req_data,
    input  logic                 bd_we,
    input  logic [ROW_WIDTH-1:0] bd_row,
    input  logic [31:0]          bd_data,
    input  logic [ROW_WIDTH-1:0] rd_row,
    output logic [31:0]          rd_data
);

    logic [31:0] ram [1 << ROW_WIDTH];

    // Backdoor word first, then request bytes, so request lanes win a same-word collision
    always_ff @(posedge clk) begin
        if (bd_we) begin
            ram[bd_row] <= bd_data;
        end
        if (req_we) begin
            for (int i = 0; i < 4; i++) begin
                if (req_be[i]) begin
                    ram[req_row][8*i +: 8] <= req_data[8*i +: 8];
                end
            end
        end
    end

    assign rd_data = ram[rd_row];

endmodule

// File: rtl/dcache_mem_responder.sv
// Memory-side responder for the dcache miss/write-through interface.
// Writes complete in the accept cycle; reads return a whole line after a
// fixed latency, one read in flight at a time. Backed by banked word RAM.
module dcache_mem_responder
    import dcache_mem_responder_pkg::*;
#(
    parameter int offset_width   = DCACHE_OFFSET_WIDTH,
    parameter int mem_addr_width = MEM_ADDR_WIDTH,
    parameter int read_latency   = READ_LATENCY
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             dcache_mem_req,
    input  logic                             dcache_mem_wr,
    input  logic [1:0]                       dcache_mem_size,
    input  logic [3:0]                       dcache_mem_wstrb,
    input  logic [31:0]                      dcache_mem_addr,
    input  logic [31:0]                      dcache_mem_data,
    output logic                             mem_dcache_addrOK,
    output logic                             mem_dcache_dataOK,
    output logic [32*(1<<offset_width)-1:0]  mem_dcache_data,
    input  logic                             bd_we,
    input  logic [mem_addr_width-1:0]        bd_addr,
    input  logic [31:0]                      bd_data,
    output logic [31:0]                      rd_count,
    output logic [31:0]                      wr_count
);

    localparam int NUM_BANKS = 1 << offset_width;
    localparam int ROW_W     = mem_addr_width - offset_width;
    localparam int LINE_W    = 32 * NUM_BANKS;

    resp_state_e             state_q, state_d;
    logic [ROW_W-1:0]        line_row_q, line_row_d;
    logic [3:0]              lat_cnt_q, lat_cnt_d;
    logic [LINE_W-1:0]       line_q, line_d;
    logic [31:0]             rd_count_q, rd_count_d;
    logic [31:0]             wr_count_q, wr_count_d;

    logic                    addr_ok;
    logic                    data_ok;
    logic                    accept_rd;
    logic                    accept_wr;
    logic [3:0]              eff_be;
    logic [mem_addr_width-1:0] req_word;
    logic [offset_width-1:0] req_bank;
    logic [ROW_W-1:0]        req_row;
    logic [offset_width-1:0] bd_bank;
    logic [ROW_W-1:0]        bd_row;
    logic [ROW_W-1:0]        rd_row;
    logic [31:0]             bank_rd [NUM_BANKS];
    logic [LINE_W-1:0]       line_rd;
    logic                    unused_addr_bits;

    // Upper address bits alias onto the RAM and are intentionally dropped
    assign unused_addr_bits = ^dcache_mem_addr[31:2+mem_addr_width];

    assign req_word  = dcache_mem_addr[2+mem_addr_width-1:2];
    assign req_bank  = req_word[offset_width-1:0];
    assign req_row   = req_word[mem_addr_width-1:offset_width];
    assign bd_bank   = bd_addr[offset_width-1:0];
    assign bd_row    = bd_addr[mem_addr_width-1:offset_width];
    assign eff_be    = dcache_mem_wstrb & size_mask(dcache_mem_size, dcache_mem_addr[1:0]);
    assign accept_rd = addr_ok & ~dcache_mem_wr;
    assign accept_wr = addr_ok & dcache_mem_wr;

    // While idle the banks look at the incoming line so a latency-1 read can capture at accept
    assign rd_row = (state_q == IDLE) ? req_row : line_row_q;

    genvar b;
    generate
        for (b = 0; b < NUM_BANKS; b++) begin : g_bank
            mem_bank_ram #(.ROW_WIDTH(ROW_W)) u_bank (
                .clk      (clk),
                .req_we   (accept_wr && (req_bank == offset_width'(b))),
                .req_row  (req_row),
                .req_be   (eff_be),
                .req_data (dcache_mem_data),
                .bd_we    (bd_we && (bd_bank == offset_width'(b))),
                .bd_row   (bd_row),
                .bd_data  (bd_data),
                .rd_row   (rd_row),
                .rd_data  (bank_rd[b])
            );
            assign line_rd[32*b +: 32] = bank_rd[b];
        end
    endgenerate

    // State, line, latency counter and request counters
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            line_row_q <= '0;
            lat_cnt_q  <= '0;
            line_q     <= '0;
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            state_q    <= state_d;
            line_row_q <= line_row_d;
            lat_cnt_q  <= lat_cnt_d;
            line_q     <= line_d;
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    // Next state: latch the read line, count down the latency, capture the line on the last wait cycle
    always_comb begin
        state_d    = state_q;
        line_row_d = line_row_q;
        lat_cnt_d  = lat_cnt_q;
        line_d     = line_q;
        rd_count_d = rd_count_q + 32'(accept_rd);
        wr_count_d = wr_count_q + 32'(accept_wr);
        case (state_q)
            IDLE: begin
                if (accept_rd) begin
                    line_row_d = req_row;
                    lat_cnt_d  = 4'(read_latency - 1);
                    if (read_latency == 1) begin
                        line_d  = line_rd;
                        state_d = RD_RESP;
                    end else begin
                        state_d = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                lat_cnt_d = lat_cnt_q - 4'd1;
                if (lat_cnt_d == 4'd0) begin
                    line_d  = line_rd;
                    state_d = RD_RESP;
                end
            end
            RD_RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs: accept only while idle and out of reset; dataOK marks the response cycle
    always_comb begin
        addr_ok = rstn && (state_q == IDLE) && dcache_mem_req;
        data_ok = (state_q == RD_RESP);
    end

    assign mem_dcache_addrOK = addr_ok;
    assign mem_dcache_dataOK = data_ok;
    assign mem_dcache_data   = line_q;
    assign rd_count          = rd_count_q;
    assign wr_count          = wr_count_q;

endmodule

// File: tb/tb_dcache_mem_responder.sv
// Bench for dcache_mem_responder: a latency-3 and a latency-1 instance share
// the backdoor, a transaction-level model predicts every output each cycle,
// and directed tests pin the model with hand-computed values.
module tb_dcache_mem_responder;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req [2];
    logic        wr [2];
    logic [1:0]  size [2];
    logic [3:0]  wstrb [2];
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic        addr_ok [2];
    logic        data_ok [2];
    logic [127:0] line [2];
    logic [31:0] rdc [2];
    logic [31:0] wrc [2];
    logic        bd_we;
    logic [9:0]  bd_addr;
    logic [31:0] bd_data;

    // model state
    logic [31:0]  mem_m [2][1024];
    bit           infl [2];
    int           age [2];
    int           base_m [2];
    logic [127:0] exp_line [2];
    logic [31:0]  exp_rd [2];
    logic [31:0]  exp_wr [2];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int acc_cyc [2];
    int last_dok [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dcache_mem_responder #(.offset_width(2), .mem_addr_width(10), .read_latency(3)) u_dut3 (
        .clk(clk), .rstn(rstn),
        .dcache_mem_req(req[0]), .dcache_mem_wr(wr[0]), .dcache_mem_size(size[0]),
        .dcache_mem_wstrb(wstrb[0]), .dcache_mem_addr(addr[0]), .dcache_mem_data(wdata[0]),
        .mem_dcache_addrOK(addr_ok[0]), .mem_dcache_dataOK(data_ok[0]), .mem_dcache_data(line[0]),
        .bd_we(bd_we), .bd_addr(bd_addr), .bd_data(bd_data),
        .rd_count(rdc[0]), .wr_count(wrc[0])
    );

    dcache_mem_responder #(.offset_width(2), .mem_addr_width(10), .read_latency(1)) u_dut1 (
        .clk(clk), .rstn(rstn),
        .dcache_mem_req(req[1]), .dcache_mem_wr(wr[1]), .dcache_mem_size(size[1]),
        .dcache_mem_wstrb(wstrb[1]), .dcache_mem_addr(addr[1]), .dcache_mem_data(wdata[1]),
        .mem_dcache_addrOK(addr_ok[1]), .mem_dcache_dataOK(data_ok[1]), .mem_dcache_data(line[1]),
        .bd_we(bd_we), .bd_addr(bd_addr), .bd_data(bd_data),
        .rd_count(rdc[1]), .wr_count(wrc[1])
    );

    function automatic int lat_of(int k);
        return (k == 0) ? 3 : 1;
    endfunction

    function automatic logic [127:0] line_of(int k, int b);
        logic [127:0] l;
        for (int i = 0; i < 4; i++) l[32*i +: 32] = mem_m[k][b + i];
        return l;
    endfunction

    // does a request of size s at address a cover byte lane i
    function automatic bit lane_hit(logic [1:0] s, logic [31:0] a, int i);
        if (s == 2'd0) return i == int'(a[1:0]);
        if (s == 2'd1) return (i / 2) == int'(a[1]);
        return 1'b1;
    endfunction

    task automatic checkOutput(string name, logic [127:0] act, logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeoutFail(string name);
        n_cmp++;
        n_bad++;
        $display("[TB] FAIL %s: got no response expected one within 64 cycles", name);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            infl[k] = 0; age[k] = 0; base_m[k] = 0;
            exp_line[k] = '0; exp_rd[k] = '0; exp_wr[k] = '0;
            acc_cyc[k] = 0; last_dok[k] = 0;
        end
    end

    // transaction-level model: one read in flight, line snapshot when its latency elapses
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < 2; k++) begin
                infl[k] = 0; age[k] = 0;
                exp_line[k] = '0; exp_rd[k] = '0; exp_wr[k] = '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin : per_dut
                bit acc;
                int w;
                acc = req[k] && !infl[k];
                w = int'(addr[k][11:2]);
                if (infl[k]) begin
                    if (age[k] == lat_of(k)) infl[k] = 0;
                    else begin
                        age[k]++;
                        if (age[k] == lat_of(k)) exp_line[k] = line_of(k, base_m[k]);
                    end
                end else if (acc && !wr[k]) begin
                    infl[k] = 1;
                    age[k] = 1;
                    base_m[k] = (w / 4) * 4;
                    exp_rd[k]++;
                    if (lat_of(k) == 1) exp_line[k] = line_of(k, base_m[k]);
                end
                if (bd_we) mem_m[k][int'(bd_addr)] = bd_data;
                if (acc && wr[k]) begin
                    exp_wr[k]++;
                    for (int i = 0; i < 4; i++)
                        if (wstrb[k][i] && lane_hit(size[k], addr[k], i))
                            mem_m[k][w][8*i +: 8] = wdata[k][8*i +: 8];
                end
            end
        end
    end

    // every-cycle comparison of both instances against the model
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (data_ok[k]) last_dok[k] = cyc;
            checkOutput($sformatf("dut%0d addrOK", k), 128'(addr_ok[k]), 128'(rstn && req[k] && !infl[k]));
            checkOutput($sformatf("dut%0d dataOK", k), 128'(data_ok[k]), 128'(infl[k] && age[k] == lat_of(k)));
            checkOutput($sformatf("dut%0d line", k), line[k], exp_line[k]);
            checkOutput($sformatf("dut%0d rd_count", k), 128'(rdc[k]), 128'(exp_rd[k]));
            checkOutput($sformatf("dut%0d wr_count", k), 128'(wrc[k]), 128'(exp_wr[k]));
        end
    end

    task automatic applyStimulus(int k, logic w, logic [1:0] s, logic [3:0] be,
                                 logic [31:0] a, logic [31:0] d);
        int n;
        n = 0;
        req[k] = 1'b1; wr[k] = w; size[k] = s; wstrb[k] = be; addr[k] = a; wdata[k] = d;
        while (n < 64) begin
            @(negedge clk);
            if (addr_ok[k]) break;
            n++;
        end
        if (n >= 64) timeoutFail($sformatf("dut%0d accept", k));
        else acc_cyc[k] = cyc;
        @(posedge clk); #1;
        req[k] = 1'b0;
    endtask

    task automatic waitData(int k);
        int n;
        n = 0;
        while (n < 64) begin
            @(negedge clk);
            if (data_ok[k]) break;
            n++;
        end
        if (n >= 64) timeoutFail($sformatf("dut%0d dataOK", k));
        @(posedge clk); #1;
    endtask

    task automatic bdWrite(logic [9:0] a, logic [31:0] d);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        @(posedge clk); #1;
        bd_we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no end of test expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int seen;
        for (int k = 0; k < 2; k++) begin
            req[k] = 0; wr[k] = 0; size[k] = 0; wstrb[k] = 0; addr[k] = 0; wdata[k] = 0;
        end
        bd_we = 0; bd_addr = 0; bd_data = 0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset rd_count", 128'(rdc[0]), 128'(0));
        checkOutput("reset line", line[0], 128'(0));
        checkOutput("reset dataOK", 128'(data_ok[0]), 128'(0));
        rstn = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) bdWrite(10'(i), 32'h1000 + 32'(i));

        // line read at 0x10, latency 3
        applyStimulus(0, 1'b0, 2'd2, 4'hF, 32'h10, 32'h0);
        waitData(0);
        checkOutput("t1 latency", 128'(last_dok[0] - acc_cyc[0]), 128'(3));
        checkOutput("t1 line", line[0], 128'h00001007_00001006_00001005_00001004);
        checkOutput("t1 rd_count", 128'(rdc[0]), 128'(1));

        // word write then line read
        applyStimulus(0, 1'b1, 2'd2, 4'hF, 32'h8, 32'hDEADBEEF);
        checkOutput("t2 wr_count", 128'(wrc[0]), 128'(1));
        applyStimulus(0, 1'b0, 2'd2, 4'hF, 32'h0, 32'h0);
        waitData(0);
        checkOutput("t2 word2", 128'(line[0][95:64]), 128'(32'hDEADBEEF));

        // byte then half write into word1
        bdWrite(10'd1, 32'h11223344);
        applyStimulus(0, 1'b1, 2'd0, 4'hF, 32'h5, 32'h0000AB00);
        applyStimulus(0, 1'b0, 2'd2, 4'hF, 32'h0, 32'h0);
        waitData(0);
        checkOutput("t3 byte write", 128'(line[0][63:32]), 128'(32'h1122AB44));
        applyStimulus(0, 1'b1, 2'd1, 4'hF, 32'h6, 32'h55660000);
        applyStimulus(0, 1'b0, 2'd2, 4'hF, 32'h0, 32'h0);
        waitData(0);
        checkOutput("t3 half write", 128'(line[0][63:32]), 128'(32'h5566AB44));

        // write held during read wait is accepted the cycle after dataOK
        applyStimulus(0, 1'b0, 2'd2, 4'hF, 32'h10, 32'h0);
        applyStimulus(0, 1'b1, 2'd2, 4'hF, 32'h14, 32'hCAFEF00D);
        checkOutput("t4 accept after dataOK", 128'(acc_cyc[0] - last_dok[0]), 128'(1));
        checkOutput("t4 read excludes write", 128'(line[0][63:32]), 128'(32'h1005));
        applyStimulus(0, 1'b0, 2'd2, 4'hF, 32'h10, 32'h0);
        waitData(0);
        checkOutput("t4 write landed", 128'(line[0][63:32]), 128'(32'hCAFEF00D));

        // latency 1 with aliased high address bits
        applyStimulus(1, 1'b0, 2'd2, 4'hF, 32'hFFFF_F010, 32'h0);
        waitData(1);
        checkOutput("t5 latency", 128'(last_dok[1] - acc_cyc[1]), 128'(1));
        checkOutput("t5 alias line", line[1], 128'h00001007_00001006_00001005_00001004);

        // reset during the read wait drops the read but keeps RAM
        applyStimulus(0, 1'b0, 2'd2, 4'hF, 32'h0, 32'h0);
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("t6 rd_count in reset", 128'(rdc[0]), 128'(0));
        checkOutput("t6 wr_count in reset", 128'(wrc[0]), 128'(0));
        rstn = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (data_ok[0]) seen++;
        end
        checkOutput("t6 no late dataOK", 128'(seen), 128'(0));
        @(posedge clk); #1;
        applyStimulus(0, 1'b0, 2'd2, 4'hF, 32'h10, 32'h0);
        waitData(0);
        checkOutput("t6 ram kept", line[0], 128'h00001007_00001006_CAFEF00D_00001004);
        checkOutput("t6 rd_count after reset", 128'(rdc[0]), 128'(1));

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dcache_mem_responder.md
Name: dcache_mem_responder

Overview:
- Memory-side responder for the data cache's miss/write-through request interface (req/wr/size/wstrb/addr/data in; addrOK/dataOK/line data out).
- Accepts single-word writes and full-line read refills.
- Backed by an internal word-addressed, banked RAM.
- Serves as the dcache's memory model in simulation and as the on-chip backing store for bring-up.

Parameters:
- offset_width, 2, log2(words per cache line); refill returns 2^offset_width words.
- mem_addr_width, 10, log2(RAM depth in 32-bit words).
- read_latency, 3, cycles from read-accept edge to dataOK; legal range 1..15.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- dcache_mem_req  in  1  request valid; held by requester until addrOK
- dcache_mem_wr  in  1  1=write, 0=read
- dcache_mem_size  in  2  0=byte, 1=half, 2=word, 3=treated as word
- dcache_mem_wstrb  in  4  byte write enables
- dcache_mem_addr  in  32  byte address
- dcache_mem_data  in  32  write data, already lane-aligned
- mem_dcache_addrOK  out  1  request (address+data) accepted this cycle
- mem_dcache_dataOK  out  1  read line data valid, one-cycle pulse
- mem_dcache_data  out  32*2^offset_width  refill line; word i at bits [32i+31:32i]
- bd_we  in  1  backdoor word write (bench/loader)
- bd_addr  in  mem_addr_width  backdoor word index
- bd_data  in  32  backdoor data
- rd_count  out  32  accepted reads, wraps at 2^32
- wr_count  out  32  accepted writes, wraps at 2^32

Behaviour:
- Reset values: state IDLE; addrOK=0, dataOK=0, mem_dcache_data=0, counters=0, latency counter=0. RAM array is not reset.
- States: IDLE, RD_WAIT, RD_RESP.
- IDLE:
  - addrOK = req, combinational, same cycle. Requester sees acceptance the cycle it asserts req.
  - Write: req&&wr. RAM written at that clock edge; stay IDLE; wr_count++. No dataOK is ever issued for writes.
  - Read: req&&!wr. Latch line index addr[2+mem_addr_width-1 : 2+offset_width] and set lat_cnt=read_latency-1. Go RD_WAIT, or go directly to RD_RESP when read_latency=1. rd_count++.
- RD_WAIT: addrOK=0 and req is ignored. Decrement lat_cnt each cycle; at lat_cnt==0, register the full line into mem_dcache_data and go RD_RESP.
- RD_RESP: dataOK=1 for exactly this cycle; mem_dcache_data stable; addrOK=0. Next state IDLE.
  - Total timing: accept edge + read_latency cycles gives the dataOK cycle.
  - The next request can be accepted the cycle after dataOK.
- mem_dcache_data holds its last value until the next line capture.
- Byte enable: eff_be = wstrb & mask.
  - size 0: mask = 1<<addr[1:0].
  - size 1: mask = addr[1] ? 4'b1100 : 4'b0011.
  - size 2/3: mask = 4'b1111.
  - eff_be=0 still counts as an accepted write, with no RAM change.
- Address: word index = addr[2+mem_addr_width-1:2]; upper bits are ignored, so addresses alias/wrap. For reads, the line base clears the low offset_width bits of the word index.
- Banking: 2^offset_width banks, bank = word_index[offset_width-1:0]. A full line is read in one cycle.
- Backdoor: bd_we writes the full word at any state.
  - Same-cycle, same-word collision with an accepted request write: merge per byte, request bytes win.
  - Backdoor writes landing before the line-capture edge are visible in the returned line.
- Reset mid-operation: immediate return to IDLE, dataOK deasserted, pending read dropped (no late dataOK). RAM contents retained.
- No outstanding-request queue: exactly one read in flight.

Decomposition:
- Shared package (alongside the cache constants):
  - state encoding localparams IDLE/RD_WAIT/RD_RESP;
  - size codes SZ_BYTE/SZ_HALF/SZ_WORD;
  - a function size_mask(size, addr_lo).
- One natural sub-module: mem_bank_ram, a single-bank word RAM with 4-bit byte-write enable and async/comb read, instantiated 2^offset_width times via generate.

Test Plan:
- Backdoor-load words 0..7 with 0x1000+i; read req addr=0x10, read_latency=3 -> addrOK in the req cycle; dataOK exactly 3 cycles after the accept edge; data={0x1007,0x1006,0x1005,0x1004}; rd_count=1.
- Word write addr=0x8, size=2, wstrb=1111, data=0xDEADBEEF; then read line at 0x0 -> addrOK same cycle, no dataOK for the write; returned word2=0xDEADBEEF; wr_count=1.
- Byte write addr=0x5, size=0, wstrb=1111, data=0x0000AB00 onto 0x11223344 -> word1=0x1122AB44. Half write addr=0x6, size=1, data=0x55660000 -> word1=0x5566AB44.
- Read accepted, then req held high during RD_WAIT with a write -> addrOK=0 until the cycle after dataOK; the write is then accepted; the earlier read data excludes it.
- read_latency=1 and addr=0xFFFF_F010 with mem_addr_width=10 -> dataOK 1 cycle after accept; data equals the line at word index 4 (aliasing).
- rstn pulled low during RD_WAIT -> dataOK never asserts; after release, IDLE with counters=0; a new read returns the RAM contents written before reset.
